controlador_exibicao: RTL and testbench
=======================================

CONTROLADOR_EXIBICAO -- requirements
Module: controlador_exibicao

Interface
REQ-001 The block SHALL have parameter T_ON, default 1000, meaning LED-on cycles per sequence item (legal range >= 1).
REQ-002 The block SHALL have parameter T_OFF, default 500, meaning LED-off gap cycles after each item (legal range >= 1).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port iniciar, input, 1 bit: start request, sampled only in OCIOSO.
REQ-006 The block SHALL have port cancela, input, 1 bit: abort the display sequence.
REQ-007 The block SHALL have port limite, input, 4 bits: index of the last item to show; N = limite+1 items.
REQ-008 The block SHALL have port dado_mem, input, 4 bits: one-hot item from the sequence memory, valid one cycle after endereco changes.
REQ-009 The block SHALL have port endereco, output, 4 bits: sequence memory address.
REQ-010 The block SHALL have port leds, output, 4 bits: registered LED drive.
REQ-011 The block SHALL have port ocupado, output, 1 bit: high in every state except OCIOSO.
REQ-012 The block SHALL have port pronto, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port db_estado, output, 3 bits: state code, OCIOSO=0, CARREGA=1, ACESO=2, APAGADO=3, FIM=4.

Function
REQ-014 The FSM SHALL have exactly these states: OCIOSO, CARREGA, ACESO, APAGADO, FIM.
REQ-015 OCIOSO SHALL, on iniciar=1 and cancela=0, clear endereco to 0 and go to CARREGA; otherwise it stays and holds endereco.
REQ-016 CARREGA SHALL last exactly 1 cycle, then go to ACESO, loading leds with dado_mem and clearing the timing counter.
REQ-017 ACESO SHALL hold leds constant for exactly T_ON cycles, then go to APAGADO.
REQ-018 APAGADO SHALL drive leds=0 for exactly T_OFF cycles.
REQ-019 At the end of APAGADO, the FSM SHALL go to FIM if endereco==limite; otherwise it SHALL increment endereco and go to CARREGA.
REQ-020 endereco SHALL never wrap; limite=15 gives 16 items with endereco ending at 15.
REQ-021 FIM SHALL assert pronto for exactly one cycle, then go to OCIOSO.
REQ-022 pronto SHALL first be high after the N*(1+T_ON+T_OFF)-th rising edge following the edge that sampled iniciar.
REQ-023 The timing counter SHALL be 16 bits; T_ON and T_OFF SHALL be <= 65535.
REQ-024 limite SHALL be sampled continuously; changing it mid-sequence is undefined.
REQ-025 iniciar asserted outside OCIOSO SHALL be ignored, with no queuing.
REQ-026 cancela=1 in any state SHALL, at the next edge, force OCIOSO with leds=0 and pronto=0, and no pronto pulse SHALL follow.
REQ-027 cancela SHALL take priority over iniciar when both are high in OCIOSO.
REQ-028 leds, ocupado and pronto SHALL all be registered, with no combinational path from inputs.

Reset
REQ-029 reset=1 at a rising edge SHALL force OCIOSO, endereco=0, leds=0, pronto=0, ocupado=0, db_estado=0 and timing counter=0.
REQ-030 reset SHALL take priority over cancela and iniciar, and SHALL abort any state including mid-ACESO.

Configuration
REQ-031 Macro PISCA_FIM_EN SHALL select the end-of-sequence behaviour.
REQ-032 With PISCA_FIM_EN defined, FIM SHALL drive leds=4'b1111 for T_OFF cycles, then assert pronto for 1 cycle, then go to OCIOSO; REQ-022 latency increases by T_OFF; cancela and reset apply during the flash.
REQ-033 Without PISCA_FIM_EN, FIM SHALL drive leds=0 and behave exactly as REQ-021.

Verification (bench uses T_ON=3, T_OFF=2)
REQ-034 Scenario: reset, limite=2, memory {0001,0010,0100}, pulse iniciar -> leds sequence 0001x3, 0000x2, 0010x3, 0000x2, 0100x3, 0000x2; pronto high 18 edges after the start edge, exactly 1 cycle.
REQ-035 Scenario: limite=15, memory all 1000 -> endereco steps 0..15 with no wrap; pronto after 96 edges; ocupado high throughout.
REQ-036 Scenario: cancela pulsed during the second ACESO -> next cycle state OCIOSO, leds=0, ocupado=0; no pronto in the following 50 cycles.
REQ-037 Scenario: iniciar re-pulsed during APAGADO, and iniciar+cancela together in OCIOSO -> timing unchanged in the first case; state remains OCIOSO in the second.
REQ-038 Scenario: reset asserted mid-ACESO -> all outputs at reset values after that edge; a new iniciar restarts from endereco=0.
REQ-039 Scenario: PISCA_FIM_EN defined, limite=0 -> leds 0001x3, 0000x2, 1111x2; pronto 8 edges after the start edge.

Source files
------------

// File: rtl/controlador_exibicao.sv
// Sequence display controller: fetches one-hot items from memory, lights them for T_ON
// cycles with T_OFF gaps, pulses pronto when done. Optional macro PISCA_FIM_EN adds an end flash.
module controlador_exibicao #(
    parameter int T_ON  = 1000,
    parameter int T_OFF = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       cancela,
    input  logic [3:0] limite,
    input  logic [3:0] dado_mem,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [2:0] db_estado
);

    // state   | meaning
    // OCIOSO  | idle, waiting for iniciar
    // CARREGA | one-cycle memory fetch for current endereco
    // ACESO   | item shown on leds for T_ON cycles
    // APAGADO | leds dark for T_OFF cycles, then next item or FIM
    // FIM     | completion (optional all-on flash), pronto pulse
    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACESO   = 3'd2,
        APAGADO = 3'd3,
        FIM     = 3'd4
    } estado_t;

    localparam logic [15:0] L_ON_ULT  = 16'(T_ON - 1);
    localparam logic [15:0] L_OFF_ULT = 16'(T_OFF - 1);

    estado_t     r_estado;
    logic [15:0] r_cnt;
    logic [3:0]  r_endereco;
    logic [3:0]  r_leds;
    logic        r_ocupado;
    logic        r_pronto;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= OCIOSO;
            r_cnt      <= 16'd0;
            r_endereco <= 4'd0;
            r_leds     <= 4'd0;
            r_ocupado  <= 1'b0;
            r_pronto   <= 1'b0;
        end else if (cancela) begin
            r_estado  <= OCIOSO;
            r_cnt     <= 16'd0;
            r_leds    <= 4'd0;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    r_leds   <= 4'd0;
                    r_pronto <= 1'b0;
                    if (iniciar) begin
                        r_endereco <= 4'd0;
                        r_estado   <= CARREGA;
                        r_ocupado  <= 1'b1;
                    end
                end
                CARREGA: begin
                    r_estado <= ACESO;
                    r_leds   <= dado_mem;
                    r_cnt    <= 16'd0;
                end
                ACESO: begin
                    if (r_cnt == L_ON_ULT) begin
                        r_estado <= APAGADO;
                        r_leds   <= 4'd0;
                        r_cnt    <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                APAGADO: begin
                    if (r_cnt == L_OFF_ULT) begin
                        r_cnt <= 16'd0;
                        if (r_endereco == limite) begin
                            r_estado <= FIM;
`ifdef PISCA_FIM_EN
                            r_leds   <= 4'b1111;
`else
                            r_pronto <= 1'b1;
`endif
                        end else begin
                            // limite <= 15 stops the sequence before endereco can wrap
                            r_endereco <= r_endereco + 4'd1;
                            r_estado   <= CARREGA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                FIM: begin
`ifdef PISCA_FIM_EN
                    if (r_pronto) begin
                        r_estado  <= OCIOSO;
                        r_pronto  <= 1'b0;
                        r_ocupado <= 1'b0;
                    end else if (r_cnt == L_OFF_ULT) begin
                        r_leds   <= 4'd0;
                        r_pronto <= 1'b1;
                        r_cnt    <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
`else
                    r_estado  <= OCIOSO;
                    r_leds    <= 4'd0;
                    r_pronto  <= 1'b0;
                    r_ocupado <= 1'b0;
`endif
                end
                default: begin
                    r_estado  <= OCIOSO;
                    r_cnt     <= 16'd0;
                    r_leds    <= 4'd0;
                    r_pronto  <= 1'b0;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign endereco  = r_endereco;
    assign leds      = r_leds;
    assign ocupado   = r_ocupado;
    assign pronto    = r_pronto;
    assign db_estado = r_estado;

endmodule

// File: tb/tb_controlador_exibicao.sv
// Self-checking bench for controlador_exibicao (T_ON=3, T_OFF=2): table vectors,
// randomized sequences against an arithmetic timeline model, and hand-written corner cases.
module tb_controlador_exibicao;

    localparam int T_ON  = 3;
    localparam int T_OFF = 2;
    localparam int P     = 1 + T_ON + T_OFF;
`ifdef PISCA_FIM_EN
    localparam int FL = T_OFF;
`else
    localparam int FL = 0;
`endif

    logic       clock = 1'b0;
    logic       reset, iniciar, cancela;
    logic [3:0] limite, dado_mem, endereco, leds;
    logic       ocupado, pronto;
    logic [2:0] db_estado;
    logic [3:0] mem [16];

    int checks = 0;
    int errors = 0;

    controlador_exibicao #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .cancela(cancela),
        .limite(limite), .dado_mem(dado_mem), .endereco(endereco), .leds(leds),
        .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;
    assign dado_mem = mem[endereco];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Expected outputs after the k-th edge following the start edge (k=0 is the start edge).
    function automatic void model(input int k, input int n, output int e_leds,
                                  output int e_pronto, output int e_ocup,
                                  output int e_end, output int e_est);
        int np, e, i, r;
        np = n * P;
        e  = np + FL;
        e_pronto = 0;
        e_ocup   = 1;
        e_end    = n - 1;
        e_leds   = 0;
        if (k < np) begin
            i = k / P;
            r = k % P;
            e_end = i;
            if (r == 0)         e_est = 1;
            else if (r <= T_ON) begin e_est = 2; e_leds = int'(mem[i]); end
            else                e_est = 3;
        end else if (k < e) begin
            e_est  = 4;
            e_leds = 15;
        end else if (k == e) begin
            e_est    = 4;
            e_pronto = 1;
        end else begin
            e_est  = 0;
            e_ocup = 0;
        end
    endfunction

    task automatic start_seq();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    task automatic run_trial(input int lim, input bit rnd_ini);
        int el, ep, eo, ee, es, last;
        limite = 4'(lim);
        last   = (lim + 1) * P + FL + 1;
        start_seq();
        for (int k = 0; k <= last; k++) begin
            if (k > 0) tick();
            model(k, lim + 1, el, ep, eo, ee, es);
            chk("trial_leds", int'(leds), el);
            chk("trial_pronto", int'(pronto), ep);
            chk("trial_ocupado", int'(ocupado), eo);
            chk("trial_endereco", int'(endereco), ee);
            chk("trial_estado", int'(db_estado), es);
            iniciar = (rnd_ini && k < last) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        iniciar = 1'b0;
    endtask

    task automatic wait_pronto(output int lat, output bit drop, output int max_end);
        lat = -1;
        drop = 1'b0;
        max_end = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (int'(endereco) > max_end) max_end = int'(endereco);
            if (pronto) begin
                lat = c;
                break;
            end
            if (!ocupado) drop = 1'b1;
        end
    endtask

    typedef struct {
        int         lim;
        logic [3:0] m0, m1, m2, mr;
        int         lat;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int  lat, max_end, pc;
        bit  drop;

        vecs[0] = '{lim: 2,  m0: 4'b0001, m1: 4'b0010, m2: 4'b0100, mr: 4'b1000, lat: 18};
        vecs[1] = '{lim: 15, m0: 4'b1000, m1: 4'b1000, m2: 4'b1000, mr: 4'b1000, lat: 96};
        vecs[2] = '{lim: 0,  m0: 4'b0001, m1: 4'b0010, m2: 4'b0100, mr: 4'b1000, lat: 6};
        vecs[3] = '{lim: 4,  m0: 4'b0010, m1: 4'b0100, m2: 4'b1000, mr: 4'b0001, lat: 30};

        reset = 1'b1; iniciar = 1'b0; cancela = 1'b0; limite = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 4'b0001;
        tick(); tick();
        chk("rst_estado", int'(db_estado), 0);
        chk("rst_leds", int'(leds), 0);
        chk("rst_endereco", int'(endereco), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_pronto", int'(pronto), 0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 16; i++) mem[i] = vecs[v].mr;
            mem[0] = vecs[v].m0; mem[1] = vecs[v].m1; mem[2] = vecs[v].m2;
            limite = 4'(vecs[v].lim);
            start_seq();
            wait_pronto(lat, drop, max_end);
            chk("vec_latency", lat, vecs[v].lat + FL);
            chk("vec_ocupado_held", int'(drop), 0);
            chk("vec_max_endereco", max_end, vecs[v].lim);
            chk("vec_end_endereco", int'(endereco), vecs[v].lim);
            tick();
            chk("vec_pronto_width", int'(pronto), 0);
            chk("vec_idle_after", int'(ocupado), 0);
        end

        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100;
        run_trial(2, 1'b0);
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) mem[i] = 4'(1 << $urandom_range(0, 3));
            run_trial(int'($urandom_range(0, 15)), 1'b1);
        end

        // cancela during the second ACESO
        limite = 4'd2;
        start_seq();
        for (int k = 1; k <= P + 1; k++) tick();
        chk("pre_cancel_estado", int'(db_estado), 2);
        cancela = 1'b1;
        tick();
        cancela = 1'b0;
        chk("cancel_estado", int'(db_estado), 0);
        chk("cancel_leds", int'(leds), 0);
        chk("cancel_ocupado", int'(ocupado), 0);
        pc = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (pronto || db_estado != 3'd0) pc++;
        end
        chk("cancel_no_pronto", pc, 0);

        // iniciar re-pulsed during APAGADO leaves timing unchanged
        limite = 4'd1;
        start_seq();
        for (int k = 1; k <= T_ON + 1; k++) tick();
        chk("apagado_estado", int'(db_estado), 3);
        iniciar = 1'b1;
        wait_pronto(lat, drop, max_end);
        iniciar = 1'b0;
        chk("reini_latency", lat, 2 * P + FL - (T_ON + 1));
        tick(); tick();
        chk("reini_no_requeue", int'(db_estado), 0);

        // iniciar and cancela together in OCIOSO
        iniciar = 1'b1; cancela = 1'b1;
        tick();
        iniciar = 1'b0; cancela = 1'b0;
        chk("both_estado", int'(db_estado), 0);
        chk("both_ocupado", int'(ocupado), 0);
        tick();
        chk("both_estado2", int'(db_estado), 0);

        // reset mid-ACESO, then restart from endereco 0
        limite = 4'd3;
        start_seq();
        for (int k = 1; k <= P + 2; k++) tick();
        chk("pre_reset_endereco", int'(endereco), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_estado", int'(db_estado), 0);
        chk("mid_rst_leds", int'(leds), 0);
        chk("mid_rst_endereco", int'(endereco), 0);
        chk("mid_rst_ocupado", int'(ocupado), 0);
        chk("mid_rst_pronto", int'(pronto), 0);
        run_trial(3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
